// File: rtl/pwm_basico_core_if.sv
// Output bundle of the breathing PWM core. With PWM_BASICO_CICLO_EN defined
// it also carries the current duty value (low R bits) as ciclo.
`ifdef PWM_BASICO_CICLO_EN
interface pwm_basico_core_if #(parameter int R = 6);
    logic         pwm_out;
    logic [R-1:0] ciclo;

    modport master (output pwm_out, output ciclo);
    modport slave  (input  pwm_out, input  ciclo);
endinterface
`else
interface pwm_basico_core_if;
    logic pwm_out;

    modport master (output pwm_out);
    modport slave  (input  pwm_out);
endinterface
`endif

// File: rtl/pwm_basico_core.sv
// Fixed-frequency PWM with a triangle "breathing" duty sequencer, each duty held N periods.
// Optional feature: PWM_BASICO_CICLO_EN exposes the current duty (low R bits) on bus.ciclo.
module pwm_basico_core #(
    parameter int R = 6,
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                reset,
    pwm_basico_core_if.master   bus
);

    localparam int            PW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [R:0]    FULL    = {1'b1, {R{1'b0}}};
    localparam logic [R-1:0]  CNT_MAX = {R{1'b1}};
    localparam logic [PW-1:0] PC_LAST = PW'(N - 1);

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    logic [R-1:0]  cnt;
    logic [R:0]    duty;
    logic          dir;
    logic [PW-1:0] pc;
    logic          pwm_q;

    logic          period_end;
    logic          step_en;
    logic [R:0]    duty_nxt;
    logic          dir_nxt;

    assign period_end = (cnt == CNT_MAX);
    assign step_en    = period_end && (pc == PC_LAST);

    // Turnaround replaces the endpoint with its neighbour so each endpoint
    // is held only N periods rather than 2N.
    always_comb begin
        duty_nxt = duty;
        dir_nxt  = dir;
        if (dir == DIR_UP) begin
            if (duty == FULL) begin
                duty_nxt = FULL - (R+1)'(1);
                dir_nxt  = DIR_DOWN;
            end else begin
                duty_nxt = duty + (R+1)'(1);
            end
        end else begin
            if (duty == '0) begin
                duty_nxt = (R+1)'(1);
                dir_nxt  = DIR_UP;
            end else begin
                duty_nxt = duty - (R+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            duty  <= '0;
            dir   <= DIR_UP;
            pc    <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt   <= cnt + R'(1);
            // R+1-bit compare so duty == 2^R keeps the output high all period
            pwm_q <= ({1'b0, cnt} < duty);
            if (period_end) begin
                if (step_en) begin
                    pc   <= '0;
                    duty <= duty_nxt;
                    dir  <= dir_nxt;
                end else begin
                    pc   <= pc + PW'(1);
                end
            end
        end
    end

    assign bus.pwm_out = pwm_q;
`ifdef PWM_BASICO_CICLO_EN
    assign bus.ciclo   = duty[R-1:0];
`endif

endmodule

// File: tb/tb_pwm_basico_core.sv
// Bench for pwm_basico_core: default build (R=6,N=3) and a small build (R=3,N=1)
// driven from one reset, each checked per clock and per period against a triangle model.
module tb_pwm_basico_core;

    localparam int RA = 6, NA = 3, MA = 1 << RA;
    localparam int RB = 3, NB = 1, MB = 1 << RB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

`ifdef PWM_BASICO_CICLO_EN
    pwm_basico_core_if #(.R(RA)) bus_a ();
    pwm_basico_core_if #(.R(RB)) bus_b ();
`else
    pwm_basico_core_if bus_a ();
    pwm_basico_core_if bus_b ();
`endif

    pwm_basico_core #(.R(RA), .N(NA)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    pwm_basico_core #(.R(RB), .N(NB)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int checks = 0;
    int errors = 0;
    int k = 0;          // edges since reset release
    int hc_a = 0, hc_b = 0;
    int q_a[$];
    int q_b[$];

    // Duty of period p: triangle 0..m..1 repeating, each value held n periods.
    function automatic int exp_duty(input int p, input int n, input int m);
        int t;
        t = (p / n) % (2 * m);
        return (t <= m) ? t : (2 * m - t);
    endfunction

    function automatic int exp_pwm(input int kk, input int n, input int m);
        if (kk == 0) return 0;
        return (((kk - 1) % m) < exp_duty((kk - 1) / m, n, m)) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s k=%0d: observed %0d expected %0d", tag, k, obs, expv);
        end
    endtask

    task automatic step(input logic rst);
        int nk, ea, eb;
        @(negedge clk);
        reset = rst;
        nk = rst ? 0 : k + 1;
        q_a.push_back(exp_pwm(nk, NA, MA));
        q_b.push_back(exp_pwm(nk, NB, MB));
        @(posedge clk);
        #1;
        k  = nk;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        check("pwm_a", int'(bus_a.pwm_out), ea);
        check("pwm_b", int'(bus_b.pwm_out), eb);
`ifdef PWM_BASICO_CICLO_EN
        check("ciclo_a", int'(bus_a.ciclo), exp_duty(k / MA, NA, MA) % MA);
        check("ciclo_b", int'(bus_b.ciclo), exp_duty(k / MB, NB, MB) % MB);
`endif
        if (k == 0) begin
            hc_a = 0;
            hc_b = 0;
        end else begin
            hc_a += int'(bus_a.pwm_out);
            hc_b += int'(bus_b.pwm_out);
            if (k % MA == 0) begin
                check("high_cnt_a", hc_a, exp_duty((k - 1) / MA, NA, MA));
                hc_a = 0;
            end
            if (k % MB == 0) begin
                check("high_cnt_b", hc_b, exp_duty((k - 1) / MB, NB, MB));
                hc_b = 0;
            end
        end
    endtask

    initial begin
        repeat (3) step(1'b1);
        // One full breathing cycle, then into the second up-ramp until duty is
        // about 40 and the counter is mid-period.
        repeat (2 * MA * NA * MA + 40 * NA * MA + 20) step(1'b0);
        step(1'b1);
        // Restart: 192 low clocks, then the first steps of the new ramp.
        repeat (NA * MA * 8) step(1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
